// File: rtl/bpred_unit.sv
// bpred_unit: branch predictor with a direct-mapped BTB, a 2-bit counter PHT in
// bimodal or gshare mode, and a speculative global history register.
// Latency: lookup is combinational from registered state, so results appear in
// the same cycle as lk_pc. Updates take effect on the next rising edge.
// Backpressure: none; every lookup and resolve is accepted in every cycle.
// Ports: clk/rst_n (async active-low); lk_* fetch lookup (valid, pc -> taken,
// target, hit, ghr snapshot); up_* execute resolve (pc, ghr snapshot,
// branch/jump, outcome, target, mispredict); stat_* resolve/correct counters.
// Optional macro BPRED_STATS_EN builds the statistics counters. Without it,
// the counter flops are not built and the stat_* outputs are tied to 0.
module bpred_unit #(
  parameter int BHR_W     = 10,
  parameter int BTB_IDX_W = 6,
  parameter int MODE      = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lk_valid,
  input  logic [31:0]      lk_pc,
  output logic             lk_taken,
  output logic [31:0]      lk_target,
  output logic             lk_hit,
  output logic [BHR_W-1:0] lk_ghr,
  input  logic             up_valid,
  input  logic [31:0]      up_pc,
  input  logic [BHR_W-1:0] up_ghr,
  input  logic             up_branch,
  input  logic             up_jump,
  input  logic             up_taken,
  input  logic [31:0]      up_target,
  input  logic             up_mispredict,
  output logic [31:0]      stat_branches,
  output logic [31:0]      stat_correct
);

  localparam int TAG_W = 30 - BTB_IDX_W;
  localparam int BTB_N = 1 << BTB_IDX_W;
  localparam int PHT_N = 1 << BHR_W;

  logic [BHR_W-1:0] ghr;
  logic             btb_vld [BTB_N];
  logic [TAG_W-1:0] btb_tag [BTB_N];
  logic [31:0]      btb_tgt [BTB_N];
  logic             btb_jmp [BTB_N];
  logic [1:0]       pht     [PHT_N];

  // The two low PC bits are always zero for aligned instructions.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lk_pc[1:0], up_pc[1:0]};

  // Lookup side.
  logic [BTB_IDX_W-1:0] lk_bidx;
  logic [TAG_W-1:0]     lk_tag;
  logic [BHR_W-1:0]     lk_pidx;

  assign lk_bidx = lk_pc[BTB_IDX_W+1:2];
  assign lk_tag  = lk_pc[31:BTB_IDX_W+2];
  assign lk_pidx = (MODE == 1) ? (lk_pc[BHR_W+1:2] ^ ghr) : lk_pc[BHR_W+1:2];

  assign lk_hit    = lk_valid & btb_vld[lk_bidx] & (btb_tag[lk_bidx] == lk_tag);
  assign lk_taken  = lk_hit & (btb_jmp[lk_bidx] | pht[lk_pidx][1]);
  assign lk_target = lk_hit ? btb_tgt[lk_bidx] : 32'h0;
  assign lk_ghr    = ghr;

  // Update side.
  logic [BTB_IDX_W-1:0] up_bidx;
  logic [BHR_W-1:0]     up_pidx;
  logic [1:0]           pht_cur;
  logic [1:0]           pht_nxt;
  logic                 pht_wr;
  logic                 btb_wr;
  logic                 recover;

  assign up_bidx = up_pc[BTB_IDX_W+1:2];
  assign up_pidx = (MODE == 1) ? (up_pc[BHR_W+1:2] ^ up_ghr) : up_pc[BHR_W+1:2];
  assign pht_cur = pht[up_pidx];
  assign pht_wr  = up_valid & up_branch;
  assign btb_wr  = up_valid & up_taken & (up_branch | up_jump);
  assign recover = up_valid & up_mispredict;

  always_comb begin
    pht_nxt = pht_cur;
    if (up_taken) begin
      if (pht_cur != 2'b11) pht_nxt = pht_cur + 2'b01;
    end else begin
      if (pht_cur != 2'b00) pht_nxt = pht_cur - 2'b01;
    end
  end

  // A mispredict rebuilds history from the resolving instruction's snapshot
  // and overrides any speculative shift made by a lookup in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr <= '0;
    end else if (recover) begin
      ghr <= {up_ghr[BHR_W-2:0], up_taken};
    end else if (lk_hit) begin
      ghr <= {ghr[BHR_W-2:0], lk_taken};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PHT_N; i++) pht[i] <= 2'b01;
    end else if (pht_wr) begin
      pht[up_pidx] <= pht_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BTB_N; i++) btb_vld[i] <= 1'b0;
    end else if (btb_wr) begin
      btb_vld[up_bidx] <= 1'b1;
    end
  end

  // Entry payload needs no reset: it is qualified by the valid bit.
  always_ff @(posedge clk) begin
    if (btb_wr) begin
      btb_tag[up_bidx] <= up_pc[31:BTB_IDX_W+2];
      btb_tgt[up_bidx] <= up_target;
      btb_jmp[up_bidx] <= up_jump;
    end
  end

`ifdef BPRED_STATS_EN
  logic [31:0] br_cnt;
  logic [31:0] ok_cnt;
  logic        resolve;

  assign resolve = up_valid & (up_branch | up_jump);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt <= '0;
      ok_cnt <= '0;
    end else if (resolve) begin
      if (br_cnt != 32'hFFFF_FFFF) br_cnt <= br_cnt + 32'd1;
      if (!up_mispredict && ok_cnt != 32'hFFFF_FFFF) ok_cnt <= ok_cnt + 32'd1;
    end
  end

  assign stat_branches = br_cnt;
  assign stat_correct  = ok_cnt;
`else
  assign stat_branches = 32'h0;
  assign stat_correct  = 32'h0;
`endif

endmodule

// File: tb/tb_bpred_unit.sv
// tb_bpred_unit: directed and randomized checks of bpred_unit.
// Instance a is gshare (MODE=1) and is tracked by a reference model.
// Instance b is bimodal (MODE=0) and is checked with directed expectations.
module tb_bpred_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lk_valid = 1'b0;
  logic [31:0] lk_pc = 32'h0;
  logic        up_valid = 1'b0;
  logic [31:0] up_pc = 32'h0;
  logic [9:0]  up_ghr = 10'h0;
  logic        up_branch = 1'b0;
  logic        up_jump = 1'b0;
  logic        up_taken = 1'b0;
  logic [31:0] up_target = 32'h0;
  logic        up_mispredict = 1'b0;

  logic        a_taken, a_hit, b_taken, b_hit;
  logic [31:0] a_target, b_target, a_sb, a_sc, b_sb, b_sc;
  logic [9:0]  a_ghr, b_ghr;

  int checks = 0;
  int failures = 0;

  bpred_unit #(.BHR_W(10), .BTB_IDX_W(6), .MODE(1)) u_gs (
    .clk(clk), .rst_n(rst_n), .lk_valid(lk_valid), .lk_pc(lk_pc),
    .lk_taken(a_taken), .lk_target(a_target), .lk_hit(a_hit), .lk_ghr(a_ghr),
    .up_valid(up_valid), .up_pc(up_pc), .up_ghr(up_ghr), .up_branch(up_branch),
    .up_jump(up_jump), .up_taken(up_taken), .up_target(up_target),
    .up_mispredict(up_mispredict), .stat_branches(a_sb), .stat_correct(a_sc)
  );

  bpred_unit #(.BHR_W(10), .BTB_IDX_W(6), .MODE(0)) u_bm (
    .clk(clk), .rst_n(rst_n), .lk_valid(lk_valid), .lk_pc(lk_pc),
    .lk_taken(b_taken), .lk_target(b_target), .lk_hit(b_hit), .lk_ghr(b_ghr),
    .up_valid(up_valid), .up_pc(up_pc), .up_ghr(up_ghr), .up_branch(up_branch),
    .up_jump(up_jump), .up_taken(up_taken), .up_target(up_target),
    .up_mispredict(up_mispredict), .stat_branches(b_sb), .stat_correct(b_sc)
  );

  always #5 clk = ~clk;

  // Reference model of instance a (BTB 64 entries, PHT 1024 counters).
  bit          m_v   [64];
  int unsigned m_tag [64];
  logic [31:0] m_tgt [64];
  bit          m_j   [64];
  int          m_pht [1024];
  int unsigned m_ghr;
  int unsigned m_nbr;
  int unsigned m_nok;

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_v[i] = 1'b0;
    for (int i = 0; i < 1024; i++) m_pht[i] = 1;
    m_ghr = 0;
    m_nbr = 0;
    m_nok = 0;
  endtask

  task automatic model_lookup(output bit hit, output bit tk, output logic [31:0] tgt);
    logic [5:0] bi;
    logic [9:0] pi;
    bi  = 6'((lk_pc / 4) % 64);
    pi  = 10'(((lk_pc / 4) ^ m_ghr) % 1024);
    hit = lk_valid && m_v[bi] && (m_tag[bi] == lk_pc / 256);
    tk  = hit && (m_j[bi] || m_pht[pi] >= 2);
    tgt = hit ? m_tgt[bi] : 32'h0;
  endtask

  task automatic model_edge();
    bit hit, tk;
    logic [31:0] tgt;
    logic [5:0] bi;
    logic [9:0] pi;
    int unsigned ng;
    model_lookup(hit, tk, tgt);
    ng = m_ghr;
    if (up_valid && up_mispredict) ng = (int'(up_ghr) * 2 + int'(up_taken)) % 1024;
    else if (hit) ng = (m_ghr * 2 + int'(tk)) % 1024;
    if (up_valid && up_branch) begin
      pi = 10'(((up_pc / 4) ^ int'(up_ghr)) % 1024);
      if (up_taken) m_pht[pi] = (m_pht[pi] == 3) ? 3 : m_pht[pi] + 1;
      else          m_pht[pi] = (m_pht[pi] == 0) ? 0 : m_pht[pi] - 1;
    end
    if (up_valid && up_taken && (up_branch || up_jump)) begin
      bi = 6'((up_pc / 4) % 64);
      m_v[bi] = 1'b1;
      m_tag[bi] = up_pc / 256;
      m_tgt[bi] = up_target;
      m_j[bi] = up_jump;
    end
    if (up_valid && (up_branch || up_jump)) begin
      m_nbr++;
      if (!up_mispredict) m_nok++;
    end
    m_ghr = ng;
  endtask

  function automatic logic [31:0] exp_br();
`ifdef BPRED_STATS_EN
    return m_nbr;
`else
    return 32'h0;
`endif
  endfunction

  function automatic logic [31:0] exp_ok();
`ifdef BPRED_STATS_EN
    return m_nok;
`else
    return 32'h0;
`endif
  endfunction

  task automatic drive(input logic lv, input logic [31:0] lpc, input logic uv,
                       input logic [31:0] upc, input logic [9:0] ughr,
                       input logic br, input logic j, input logic tk,
                       input logic [31:0] tgt, input logic mis);
    lk_valid = lv; lk_pc = lpc; up_valid = uv; up_pc = upc; up_ghr = ughr;
    up_branch = br; up_jump = j; up_taken = tk; up_target = tgt; up_mispredict = mis;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 10'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  // Advance one clock; the model consumes the inputs seen before the edge.
  task automatic step();
    @(negedge clk);
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    drive(1'b1, 32'h60, 1'b0, 32'h0, 10'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    #2;
    checks++; if ({a_hit, a_taken, b_hit, b_taken} !== 4'b0) begin failures++;
      $display("FAIL rst_hold_flags: got %b want 0000", {a_hit, a_taken, b_hit, b_taken}); end
    checks++; if (a_target !== 32'h0 || a_ghr !== 10'h0) begin failures++;
      $display("FAIL rst_hold_tgt_ghr: got %h/%h want 0/0", a_target, a_ghr); end
    checks++; if ({a_sb, a_sc} !== 64'h0) begin failures++;
      $display("FAIL rst_hold_stats: got %h/%h want 0/0", a_sb, a_sc); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if ({a_hit, a_taken} !== 2'b0 || a_target !== 32'h0 || a_ghr !== 10'h0) begin failures++;
      $display("FAIL post_rst_lookup: got hit=%b tk=%b tgt=%h ghr=%h want 0", a_hit, a_taken, a_target, a_ghr); end
    step();
  endtask

  task automatic test_jump();
    drive(1'b0, 32'h0, 1'b1, 32'h60, 10'h0, 1'b0, 1'b1, 1'b1, 32'h200, 1'b1);
    step();
    drive(1'b1, 32'h60, 1'b0, 32'h0, 10'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    checks++; if ({a_hit, a_taken} !== 2'b11 || a_target !== 32'h200) begin failures++;
      $display("FAIL jump_gs: got hit=%b tk=%b tgt=%h want 1 1 200", a_hit, a_taken, a_target); end
    checks++; if ({b_hit, b_taken} !== 2'b11 || b_target !== 32'h200) begin failures++;
      $display("FAIL jump_bm: got hit=%b tk=%b tgt=%h want 1 1 200", b_hit, b_taken, b_target); end
    step();
  endtask

  task automatic test_ghr_recovery();
    // Resolve with neither flag set: only the history is rebuilt, to 0x0F3.
    drive(1'b0, 32'h0, 1'b1, 32'h0, 10'h079, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1);
    step();
    idle();
    #1;
    checks++; if (a_ghr !== 10'h0F3) begin failures++;
      $display("FAIL ghr_setup: got %h want 0f3", a_ghr); end
    drive(1'b1, 32'h60, 1'b1, 32'h0, 10'h155, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    #1;
    checks++; if (a_hit !== 1'b1) begin failures++;
      $display("FAIL ghr_same_cycle_hit: got %b want 1", a_hit); end
    step();
    idle();
    #1;
    checks++; if (a_ghr !== 10'h2AA) begin failures++;
      $display("FAIL ghr_recover_priority: got %h want 2aa", a_ghr); end
    checks++; if (a_sb !== exp_br()) begin failures++;
      $display("FAIL no_flag_stats: got %h want %h", a_sb, exp_br()); end
  endtask

  task automatic test_bimodal();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 32'h0, 1'b1, 32'h80, 10'($urandom), 1'b1, 1'b0, 1'b1, 32'h40, 1'b0);
      step();
    end
    drive(1'b1, 32'h80, 1'b0, 32'h0, 10'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    checks++; if ({b_hit, b_taken} !== 2'b11 || b_target !== 32'h40) begin failures++;
      $display("FAIL bm_taken_sat: got hit=%b tk=%b tgt=%h want 1 1 40", b_hit, b_taken, b_target); end
    step();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 32'h0, 1'b1, 32'h80, 10'($urandom), 1'b1, 1'b0, 1'b0, 32'h40, 1'b1);
      step();
      drive(1'b1, 32'h80, 1'b0, 32'h0, 10'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      #1;
      checks++; if (b_hit !== 1'b1 || b_taken !== (i == 0)) begin failures++;
        $display("FAIL bm_nt_%0d: got hit=%b tk=%b want 1 %0d", i, b_hit, b_taken, (i == 0)); end
      step();
    end
  endtask

  task automatic test_alias();
    drive(1'b0, 32'h0, 1'b1, 32'h100, 10'h0, 1'b0, 1'b1, 1'b1, 32'hAAAA0000, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b1, 32'h200, 10'h0, 1'b0, 1'b1, 1'b1, 32'hBBBB0000, 1'b0);
    step();
    drive(1'b1, 32'h100, 1'b0, 32'h0, 10'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    checks++; if (a_hit !== 1'b0 || a_target !== 32'h0) begin failures++;
      $display("FAIL alias_first_miss: got hit=%b tgt=%h want 0 0", a_hit, a_target); end
    step();
    drive(1'b1, 32'h200, 1'b0, 32'h0, 10'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    checks++; if (a_hit !== 1'b1 || a_target !== 32'hBBBB0000) begin failures++;
      $display("FAIL alias_second_hit: got hit=%b tgt=%h want 1 bbbb0000", a_hit, a_target); end
    step();
    // Lookup and write of the same entry in one cycle: old contents seen.
    drive(1'b1, 32'h100, 1'b1, 32'h100, 10'h0, 1'b0, 1'b1, 1'b1, 32'hCCCC0000, 1'b0);
    #1;
    checks++; if (a_hit !== 1'b0) begin failures++;
      $display("FAIL same_cycle_pre: got hit=%b want 0", a_hit); end
    step();
    drive(1'b1, 32'h100, 1'b0, 32'h0, 10'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    checks++; if (a_hit !== 1'b1 || a_target !== 32'hCCCC0000) begin failures++;
      $display("FAIL same_cycle_post: got hit=%b tgt=%h want 1 cccc0000", a_hit, a_target); end
    step();
  endtask

  task automatic test_stats();
    logic [31:0] wb, wc;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 32'h0, 1'b1, 32'($urandom_range(0, 255)) * 4, 10'($urandom),
            1'(i % 2), 1'((i + 1) % 2), 1'($urandom), $urandom, 1'(i < 2));
      step();
    end
    idle();
    #1;
`ifdef BPRED_STATS_EN
    wb = 32'd5; wc = 32'd3;
`else
    wb = 32'd0; wc = 32'd0;
`endif
    checks++; if (a_sb !== wb || a_sc !== wc) begin failures++;
      $display("FAIL stats_5_2: got %0d/%0d want %0d/%0d", a_sb, a_sc, wb, wc); end
    checks++; if (b_sb !== wb || b_sc !== wc) begin failures++;
      $display("FAIL stats_bm: got %0d/%0d want %0d/%0d", b_sb, b_sc, wb, wc); end
  endtask

  task automatic test_random();
    logic [31:0] pool [8];
    bit hit, tk;
    logic [31:0] tgt;
    int kind;
    pool[0] = 32'h40;   pool[1] = 32'h80;   pool[2] = 32'h100; pool[3] = 32'h200;
    pool[4] = 32'h1040; pool[5] = 32'h60;   pool[6] = 32'h300; pool[7] = 32'h304;
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      kind = int'($urandom_range(0, 3));
      drive(1'($urandom), pool[$urandom_range(0, 7)], 1'($urandom), pool[$urandom_range(0, 7)],
            10'($urandom), (kind == 1 || kind == 3), (kind == 2), 1'($urandom),
            $urandom, ($urandom_range(0, 2) == 0));
      #1;
      model_lookup(hit, tk, tgt);
      checks++; if (a_hit !== hit || a_taken !== tk) begin failures++;
        $display("FAIL rnd_dir[%0d]: got hit=%b tk=%b want %b %b", n, a_hit, a_taken, hit, tk); end
      checks++; if (a_target !== tgt) begin failures++;
        $display("FAIL rnd_tgt[%0d]: got %h want %h", n, a_target, tgt); end
      checks++; if (a_ghr !== 10'(m_ghr)) begin failures++;
        $display("FAIL rnd_ghr[%0d]: got %h want %h", n, a_ghr, 10'(m_ghr)); end
      checks++; if (a_sb !== exp_br() || a_sc !== exp_ok()) begin failures++;
        $display("FAIL rnd_stats[%0d]: got %0d/%0d want %0d/%0d", n, a_sb, a_sc, exp_br(), exp_ok()); end
      step();
    end
  endtask

  task automatic test_mid_reset();
    drive(1'b0, 32'h0, 1'b1, 32'h60, 10'h0, 1'b0, 1'b1, 1'b1, 32'h500, 1'b1);
    step();
    drive(1'b1, 32'h60, 1'b0, 32'h0, 10'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    checks++; if (a_hit !== 1'b1 || a_target !== 32'h500) begin failures++;
      $display("FAIL mid_pre: got hit=%b tgt=%h want 1 500", a_hit, a_target); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if ({a_hit, a_taken, b_hit} !== 3'b0 || a_ghr !== 10'h0 || a_target !== 32'h0) begin failures++;
      $display("FAIL mid_async: got hit=%b tk=%b ghr=%h tgt=%h want 0", a_hit, a_taken, a_ghr, a_target); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (a_hit !== 1'b0 || b_hit !== 1'b0 || {a_sb, a_sc} !== 64'h0) begin failures++;
      $display("FAIL mid_after: got hit=%b/%b stats=%h/%h want 0", a_hit, b_hit, a_sb, a_sc); end
    step();
  endtask

  initial begin
    test_reset();
    test_jump();
    test_ghr_recovery();
    test_bimodal();
    test_alias();
    test_stats();
    test_random();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bpred_unit.md
BPRED_UNIT -- requirements
Module: bpred_unit

Interface
REQ-001 Parameter BHR_W, default 10: global history width; PHT has 2^BHR_W 2-bit counters; legal range 2..16.
REQ-002 Parameter BTB_IDX_W, default 6: BTB has 2^BTB_IDX_W direct-mapped entries; legal range 2..10.
REQ-003 Parameter MODE, default 1: 0 selects bimodal indexing (PC only); 1 selects gshare indexing (PC XOR history).
REQ-004 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-005 Port rst_n  input  1: asynchronous, active-low reset.
REQ-006 Port lk_valid  input  1: fetch-stage lookup request.
REQ-007 Port lk_pc  input  32: fetch PC.
REQ-008 Port lk_taken  output  1: predicted redirect.
REQ-009 Port lk_target  output  32: predicted target.
REQ-010 Port lk_hit  output  1: BTB hit.
REQ-011 Port lk_ghr  output  BHR_W: history snapshot, carried down the pipeline with the instruction.
REQ-012 Port up_valid  input  1: execute-stage resolve.
REQ-013 Port up_pc  input  32: PC of the resolving instruction.
REQ-014 Port up_ghr  input  BHR_W: that instruction's snapshot.
REQ-015 Port up_branch  input  1: conditional-branch flag.
REQ-016 Port up_jump  input  1: JAL/JALR flag.
REQ-017 Port up_taken  input  1: actual outcome.
REQ-018 Port up_target  input  32: actual target.
REQ-019 Port up_mispredict  input  1: direction or target was wrong.
REQ-020 Port stat_branches  output  32: resolved branch/jump count.
REQ-021 Port stat_correct  output  32: correctly predicted count.

Function
REQ-022 Lookup is combinational from registered state: zero-cycle latency, result valid in the same cycle as lk_pc.
REQ-023 BTB index is pc[BTB_IDX_W+1:2]; tag is pc[31:BTB_IDX_W+2]; each entry holds valid, tag, target[31:0] and jump bit.
REQ-024 PHT index is pc[BHR_W+1:2] XOR ghr when MODE=1, and pc[BHR_W+1:2] when MODE=0.
REQ-025 lk_hit = lk_valid & entry valid & tag match; lk_taken = lk_hit & (jump bit | PHT counter[1]).
REQ-026 lk_target = BTB target when lk_hit=1, else 0.
REQ-027 lk_ghr = current speculative history register value.
REQ-028 Speculative history: when lk_valid & lk_hit & no recovery, ghr <= {ghr[BHR_W-2:0], lk_taken}.
REQ-029 Recovery: when up_valid & up_mispredict, ghr <= {up_ghr[BHR_W-2:0], up_taken}; recovery takes priority over a same-cycle lookup shift.
REQ-030 PHT update: when up_valid & up_branch, the counter at index(up_pc, up_ghr) increments if up_taken and decrements otherwise, saturating at 3 and 0.
REQ-031 BTB write: when up_valid & up_taken & (up_branch | up_jump), the entry at up_pc is written with valid=1, its tag, up_target and jump=up_jump.
REQ-032 Same-cycle lookup and update to the same entry: the lookup returns the pre-update value, and the update is visible on the next cycle.
REQ-033 up_branch and up_jump both 0 with up_valid=1: no PHT, BTB or statistics change, but recovery (REQ-029) still applies.

Reset
REQ-034 While rst_n=0: ghr=0, all BTB valid bits=0, all PHT counters=2'b01 (weakly not-taken), and statistics=0.
REQ-035 After reset, outputs are lk_taken=0, lk_hit=0, lk_target=0 and lk_ghr=0; reset asserted mid-operation discards all in-flight state on the same edge.

Configuration
REQ-036 Macro BPRED_STATS_EN, when defined: stat_branches increments on up_valid & (up_branch | up_jump), and stat_correct increments on the same condition & ~up_mispredict; both saturate at 32'hFFFFFFFF.
REQ-037 Without BPRED_STATS_EN, no counter flops are built and stat_branches and stat_correct are tied to 0.

Verification
REQ-038 Reset then lk_valid=1, lk_pc=32'h60 -> lk_hit=0, lk_taken=0, lk_target=0, lk_ghr=0.
REQ-039 Resolve up_jump=1, up_taken=1, up_pc=32'h60, up_target=32'h200; next cycle lookup 32'h60 -> lk_hit=1, lk_taken=1, lk_target=32'h200.
REQ-040 MODE=0: branch at 32'h80 with target 32'h40 resolved taken twice -> counter 01->10->11; lookup -> lk_taken=1; resolved not-taken twice -> lk_taken=0 with lk_hit=1.
REQ-041 ghr=10'h0F3, up_ghr=10'h155, up_taken=0, up_mispredict=1 in the same cycle as a lookup hit -> next ghr=10'h2AA.
REQ-042 Aliasing check: pc 32'h100 and 32'h100+(4<<BTB_IDX_W) both written -> the second overwrites the first, and lookup of the first misses on the tag.
REQ-043 BPRED_STATS_EN: 5 resolves with 2 mispredicts -> stat_branches=5, stat_correct=3; macro off -> both 0.
